// File: rtl/crossbar_rr.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_rr
// Purpose  : N_SRC x N_DST valid/ready crossbar. Each source beat carries a
//            destination index. Each destination has its own arbiter and a
//            one-entry output register, giving 1 cycle of latency and
//            1 beat/cycle per destination.
//            Beats whose destination index is >= N_DST are accepted and
//            discarded, and drop pulses for one cycle afterwards.
// Options  : CROSSBAR_FIXED_PRIO_EN defined -> fixed priority arbitration
//            (lowest source index wins) and no pointer registers.
//            Undefined (default)           -> round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module crossbar_rr #(
    parameter int WIDTH = 8,
    parameter int N_SRC = 2,
    parameter int N_DST = 2,
    localparam int DW = $clog2(N_DST),
    localparam int SW = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       s_val,
    input  logic [N_SRC*DW-1:0]    s_dst,
    input  logic [N_SRC*WIDTH-1:0] s_data,
    output logic [N_SRC-1:0]       s_rdy,
    output logic [N_DST-1:0]       m_val,
    output logic [N_DST*SW-1:0]    m_src,
    output logic [N_DST*WIDTH-1:0] m_data,
    input  logic [N_DST-1:0]       m_rdy,
    output logic                   drop
);

    logic [N_SRC-1:0] w_bad;            // valid beat addressed to a missing destination
    logic [N_DST-1:0] w_found;          // destination has at least one requester
    logic [N_DST-1:0] w_load;           // destination slot loads this cycle
    logic [SW-1:0]    w_win  [N_DST];   // arbitration winner per destination
    logic [SW-1:0]    w_base [N_DST];   // source index where the search starts

`ifdef CROSSBAR_FIXED_PRIO_EN
    // Fixed priority: every search starts at source 0.
    always_comb begin
        for (int d = 0; d < N_DST; d++) begin
            w_base[d] = '0;
        end
    end
`else
    logic [SW-1:0] r_ptr [N_DST];

    // Round-robin pointer: advances past the source that just transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < N_DST; d++) begin
                r_ptr[d] <= '0;
            end
        end else begin
            for (int d = 0; d < N_DST; d++) begin
                if (w_load[d]) begin
                    r_ptr[d] <= (int'(w_win[d]) == N_SRC - 1) ? '0 : SW'(w_win[d] + 1'b1);
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < N_DST; d++) begin
            w_base[d] = r_ptr[d];
        end
    end
`endif

    // Flag valid beats whose destination index does not exist.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_bad[i] = s_val[i] && (int'(s_dst[i*DW +: DW]) >= N_DST);
        end
    end

    // Per-destination arbiter: first requester found from the base, wrapping.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        for (int d = 0; d < N_DST; d++) begin
            found    = 1'b0;
            w_win[d] = '0;
            for (int k = 0; k < N_SRC; k++) begin
                idx = int'(w_base[d]) + k;
                if (idx >= N_SRC) begin
                    idx = idx - N_SRC;
                end
                if (!found && s_val[idx] && !w_bad[idx] &&
                    (int'(s_dst[idx*DW +: DW]) == d)) begin
                    found    = 1'b1;
                    w_win[d] = SW'(idx);
                end
            end
            w_found[d] = found;
            // The slot is free when empty or being drained this cycle.
            w_load[d]  = found && (!m_val[d] || m_rdy[d]) && !rst;
        end
    end

    // Source ready: winner of a loading destination, or a discarded beat.
    always_comb begin
        s_rdy = '0;
        for (int i = 0; i < N_SRC; i++) begin
            s_rdy[i] = w_bad[i];
            for (int d = 0; d < N_DST; d++) begin
                if (w_load[d] && (int'(w_win[d]) == i)) begin
                    s_rdy[i] = 1'b1;
                end
            end
        end
        if (rst) begin
            s_rdy = '0;
        end
    end

    // Output slots and the discard pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_val  <= '0;
            m_src  <= '0;
            m_data <= '0;
            drop   <= 1'b0;
        end else begin
            for (int d = 0; d < N_DST; d++) begin
                if (w_load[d]) begin
                    m_val[d]                 <= 1'b1;
                    m_src[d*SW +: SW]        <= w_win[d];
                    m_data[d*WIDTH +: WIDTH] <= s_data[int'(w_win[d])*WIDTH +: WIDTH];
                end else if (m_rdy[d]) begin
                    m_val[d] <= 1'b0;
                end
            end
            drop <= |w_bad;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crossbar_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossbar_rr
// Purpose  : Randomised scoreboard bench for crossbar_rr (4 sources,
//            3 destinations, so destination index 3 is out of range).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crossbar_rr;

    localparam int WIDTH = 8;
    localparam int N_SRC = 4;
    localparam int N_DST = 3;
    localparam int DW    = 2;
    localparam int SW    = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_SRC-1:0]       s_val;
    logic [N_SRC*DW-1:0]    s_dst;
    logic [N_SRC*WIDTH-1:0] s_data;
    logic [N_SRC-1:0]       s_rdy;
    logic [N_DST-1:0]       m_val;
    logic [N_DST*SW-1:0]    m_src;
    logic [N_DST*WIDTH-1:0] m_data;
    logic [N_DST-1:0]       m_rdy;
    logic                   drop;

    crossbar_rr #(.WIDTH(WIDTH), .N_SRC(N_SRC), .N_DST(N_DST)) dut (
        .clk(clk), .rst(rst),
        .s_val(s_val), .s_dst(s_dst), .s_data(s_data), .s_rdy(s_rdy),
        .m_val(m_val), .m_src(m_src), .m_data(m_data), .m_rdy(m_rdy),
        .drop(drop)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected slot contents per destination, encoded as src*256 + data.
    int sb [N_DST][$];

    // Reference model state: each source's held beat and each destination's
    // next-search position.
    int hv   [N_SRC];
    int hd   [N_SRC];
    int hdat [N_SRC];
    int nxt  [N_DST];
    int mode;
    bit mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the presented slot must match the oldest expected beat.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < N_DST; d++) begin
                check($sformatf("m_val[%0d]", d), int'(m_val[d]), int'(sb[d].size() > 0));
                if (m_val[d] && sb[d].size() > 0) begin
                    check($sformatf("m_src[%0d]", d), int'(m_src[d*SW +: SW]), sb[d][0] / 256);
                    check($sformatf("m_data[%0d]", d), int'(m_data[d*WIDTH +: WIDTH]), sb[d][0] % 256);
                    if (m_rdy[d]) begin
                        void'(sb[d].pop_front());
                    end
                end
            end
        end
    end

    // One clock of stimulus: drive, predict and check grants, commit at the edge.
    task automatic run_cycle(input bit do_rst);
        int acc [N_SRC];
        int g;
        logic [N_SRC-1:0] exp_rdy;
        int exp_drop;
        int exp_load [N_DST];
        int exp_win  [N_DST];

        rst = do_rst;
        for (int d = 0; d < N_DST; d++) begin
            case (mode)
                1:       m_rdy[d] = 1'b1;
                2:       m_rdy[d] = ($urandom_range(0, 1) == 0);
                default: m_rdy[d] = ($urandom_range(0, 3) != 0);
            endcase
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (hv[i] == 0) begin
                if (mode == 1) begin
                    hv[i] = 1; hd[i] = 0;
                end else if ($urandom_range(0, 3) != 0) begin
                    hv[i] = 1;
                    hd[i] = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, N_DST - 1));
                end
                hdat[i] = int'($urandom_range(0, 255));
            end
            s_val[i]               = (hv[i] != 0);
            s_dst[i*DW +: DW]      = DW'(hd[i]);
            s_data[i*WIDTH +: WIDTH] = WIDTH'(hdat[i]);
        end

        exp_rdy  = '0;
        exp_drop = 0;
        for (int i = 0; i < N_SRC; i++) acc[i] = 0;
        for (int d = 0; d < N_DST; d++) begin
            exp_load[d] = 0;
            exp_win[d]  = 0;
        end
        if (!do_rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (hv[i] != 0 && hd[i] >= N_DST) begin
                    acc[i] = 1; exp_drop = 1;
                end
            end
            for (int d = 0; d < N_DST; d++) begin
                if (sb[d].size() == 0 || m_rdy[d]) begin
                    for (int k = 0; k < N_SRC; k++) begin
                        g = (nxt[d] + k) % N_SRC;
                        if (exp_load[d] == 0 && hv[g] != 0 && hd[g] == d) begin
                            exp_load[d] = 1; exp_win[d] = g; acc[g] = 1;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < N_SRC; i++) exp_rdy[i] = (acc[i] != 0);

        #2;
        check("s_rdy", int'(s_rdy), int'(exp_rdy));

        @(posedge clk);
        for (int d = 0; d < N_DST; d++) begin
            if (do_rst) begin
                sb[d].delete();
                nxt[d] = 0;
            end else if (exp_load[d] != 0) begin
                sb[d].push_back(exp_win[d] * 256 + hdat[exp_win[d]]);
`ifndef CROSSBAR_FIXED_PRIO_EN
                nxt[d] = (exp_win[d] + 1) % N_SRC;
`endif
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (acc[i] != 0) hv[i] = 0;
        end
        #1;
        check("drop", int'(drop), exp_drop);
    endtask

    initial begin
        rst    = 1'b1;
        s_val  = '1;
        s_dst  = '0;
        s_data = '0;
        m_rdy  = '0;
        mode   = 0;
        for (int i = 0; i < N_SRC; i++) begin hv[i] = 0; hd[i] = 0; hdat[i] = 0; end
        for (int d = 0; d < N_DST; d++) nxt[d] = 0;

        // Reset held for two cycles with every source requesting.
        repeat (2) @(posedge clk);
        #1;
        check("reset m_val",  int'(m_val),  0);
        check("reset s_rdy",  int'(s_rdy),  0);
        check("reset m_data", int'(m_data), 0);
        check("reset drop",   int'(drop),   0);
        s_val  = '0;
        mon_en = 1'b1;

        // Contention: every source targets destination 0 with the sink ready.
        mode = 1;
        repeat (12) run_cycle(1'b0);
        // Drain the held beats, then mixed random traffic.
        mode = 0;
        repeat (300) run_cycle(1'b0);
        // Heavy backpressure.
        mode = 2;
        repeat (200) run_cycle(1'b0);
        // Reset pulse while slots are likely occupied.
        run_cycle(1'b1);
        mode = 0;
        repeat (150) run_cycle(1'b0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
